interface_probe_sequencer: RTL and testbench
============================================

Name: interface_probe_sequencer

Overview:
- Phase 0 controller that drives the signal quality scorer across candidate receiver configurations (SE MFM, SE RLL, DIFF ESDI-10, DIFF ESDI-15).
- For each enabled mode it selects the receiver mode, clears the scorer, waits for the receiver to settle, enables a fixed measurement window, then captures the results.
- When all enabled modes are done it reports the best-scoring mode to the personality selection logic.
- Runs in the 300 MHz HDD clock domain.

Parameters:
- SETTLE_CYCLES, 3000, cycles held after a mode switch with the scorer disabled (10 µs); 0 means skip settle.
- WINDOW_CYCLES, 3000000, measurement window length with the scorer enabled (10 ms); must be ≥1.
- MIN_EDGES, 128, minimum scorer edge_count for a mode result to be valid.
- MIN_QUALITY, 96, minimum scorer quality for a mode result to be valid.

Ports:
- clk  in  1  300 MHz clock.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle request to begin a probe sweep; sampled only in IDLE.
- abort  in  1  terminates the sweep; honoured in any non-IDLE state.
- mode_mask  in  4  bit m enables mode m; sampled on the accepted start.
- rx_mode  out  2  receiver configuration select: 0=SE MFM, 1=SE RLL, 2=DIFF 10M, 3=DIFF 15M.
- scorer_clear  out  1  drives the scorer clear input.
- scorer_enable  out  1  drives the scorer enable input.
- scorer_quality  in  8  quality output from the scorer.
- scorer_edge_count  in  16  edge_count output from the scorer.
- scorer_best_bin  in  3  best_rate_bin output from the scorer.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on sweep completion.
- aborted  out  1  one-cycle pulse when an abort is taken.
- valid_found  out  1  at least one mode passed both thresholds.
- best_mode  out  2  winning mode index.
- best_quality  out  8  winning mode's quality.
- best_bin  out  3  winning mode's histogram bin.
- mode_quality  out  32  per-mode captured score; byte m = mode m; 0 if the mode was invalid or skipped.

Behaviour:
- Reset: synchronous, active-high, on clk. All outputs go to 0 and the FSM goes to IDLE. Reset mid-sweep discards all results.
- FSM states: IDLE, CLEAR, SETTLE, MEASURE, CAPTURE, NEXT, DONE.
- IDLE:
  - start=1 with mode_mask≠0: latch the mask, clear mode_quality, best_*, and valid_found, set idx = lowest set bit, go to CLEAR.
  - start=1 with mode_mask=0: go to DONE with valid_found=0 and all results zero.
  - start while busy is ignored.
- CLEAR (1 cycle): rx_mode=idx, scorer_clear=1, scorer_enable=0. Go to SETTLE, or to MEASURE if SETTLE_CYCLES=0.
- SETTLE: exactly SETTLE_CYCLES cycles, scorer_enable=0, scorer_clear=0. Uses a 32-bit down-counter.
- MEASURE: exactly WINDOW_CYCLES cycles with scorer_enable=1. scorer_enable must not be high in any other state.
- CAPTURE (1 cycle), scorer_enable=0:
  - sample q=scorer_quality, e=scorer_edge_count, b=scorer_best_bin.
  - Valid iff e ≥ MIN_EDGES and q ≥ MIN_QUALITY; invalid stores 0 in the mode_quality byte.
  - If valid and (valid_found=0 or q > best_quality): best_mode=idx, best_quality=q, best_bin=b, valid_found=1.
  - Ties keep the earlier (lower) index.
- NEXT (1 cycle): idx = next set mask bit above idx; go to CLEAR. If none remain, go to DONE.
- DONE (1 cycle): done=1, then go to IDLE.
- rx_mode keeps its last value in IDLE.
- Results hold until the next accepted start or reset.
- Abort:
  - in any non-IDLE state other than DONE, the next state is IDLE with aborted=1 for that one cycle and scorer_enable=0.
  - done is not pulsed.
  - results already captured (completed modes) remain visible; valid_found reflects only those.
  - Abort in DONE is ignored: done still pulses.
  - If abort and start arrive together in IDLE, start wins (abort is ignored in IDLE).
- Timing: with start accepted at cycle t and N enabled modes, done is high at cycle t + N·(SETTLE_CYCLES+WINDOW_CYCLES+3) + 1. With SETTLE_CYCLES=0, subtract N·1 per skipped settle… no: the per-mode cost becomes WINDOW_CYCLES+3 (CLEAR, CAPTURE, NEXT).
- Width rules:
  - counters are 32-bit.
  - comparisons are unsigned.
  - e is compared as 16-bit against MIN_EDGES truncated to 16 bits.

Test Plan (bench parameters: SETTLE=4, WINDOW=64, MIN_EDGES=8, MIN_QUALITY=96; scorer modelled by forced inputs):
- mask=4'b1111, q per mode = 100/200/150/200, e=500 → best_mode=1, best_quality=200 (tie with mode 3 keeps 1), valid_found=1, mode_quality=0xC8_96_C8_64, done at t+4·71+1=t+285.
- mask=4'b0101, mode 0 q=255 e=4 (too few edges), mode 2 q=97 e=500 → mode_quality byte0=0, byte2=97, best_mode=2, valid_found=1; modes 1 and 3 never appear on rx_mode.
- mask=4'b0000 → done at t+1, valid_found=0, busy high for exactly 1 cycle.
- mask=4'b1111, abort during mode 2 MEASURE → aborted pulse, no done, scorer_enable low the next cycle, modes 0–1 results retained; a new start then re-sweeps cleanly.
- Check scorer_clear: high exactly 1 cycle per mode. Check scorer_enable: high exactly 64 cycles per mode. With SETTLE=0 → clear is followed immediately by enable.
- Assert reset in SETTLE of mode 1 → all outputs 0 the next cycle, FSM in IDLE; a start pulse while busy leaves the sweep order unchanged.

Source files
------------

// File: rtl/interface_probe_sequencer.sv
// Probe sweep controller: steps the receiver through each enabled mode, runs the
// signal quality scorer for a fixed window per mode, and reports the best-scoring mode.
module interface_probe_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 3000,
  parameter int unsigned WINDOW_CYCLES = 3000000,
  parameter int unsigned MIN_EDGES     = 128,
  parameter int unsigned MIN_QUALITY   = 96
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  mode_mask,
  output logic [1:0]  rx_mode,
  output logic        scorer_clear,
  output logic        scorer_enable,
  input  logic [7:0]  scorer_quality,
  input  logic [15:0] scorer_edge_count,
  input  logic [2:0]  scorer_best_bin,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic        valid_found,
  output logic [1:0]  best_mode,
  output logic [7:0]  best_quality,
  output logic [2:0]  best_bin,
  output logic [31:0] mode_quality
);

  // start is a one-cycle request taken only in IDLE; abort wins in every busy
  // state except DONE, which always completes with its done pulse.
  typedef enum logic [2:0] {
    ST_IDLE, ST_CLEAR, ST_SETTLE, ST_MEASURE, ST_CAPTURE, ST_NEXT, ST_DONE
  } state_t;

  localparam logic [31:0] SETTLE_LOAD  = SETTLE_CYCLES - 32'd1;
  localparam logic [31:0] WINDOW_LOAD  = WINDOW_CYCLES - 32'd1;
  localparam logic [15:0] MIN_EDGES_16 = MIN_EDGES[15:0];

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  mask_q, mask_d;
  logic [1:0]  rx_mode_q, rx_mode_d;
  logic        aborted_q, aborted_d;
  logic        valid_found_q, valid_found_d;
  logic [1:0]  best_mode_q, best_mode_d;
  logic [7:0]  best_quality_q, best_quality_d;
  logic [2:0]  best_bin_q, best_bin_d;
  logic [31:0] mode_quality_q, mode_quality_d;
  logic [2:0]  nb;
  logic        mode_ok;

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [2:0] next_bit(input logic [3:0] mask, input logic [2:0] from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    mask_d         = mask_q;
    rx_mode_d      = rx_mode_q;
    aborted_d      = 1'b0;
    valid_found_d  = valid_found_q;
    best_mode_d    = best_mode_q;
    best_quality_d = best_quality_q;
    best_bin_d     = best_bin_q;
    mode_quality_d = mode_quality_q;
    nb             = 3'b000;
    mode_ok        = 1'b0;

    if (abort && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
      state_d   = ST_IDLE;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mask_d         = mode_mask;
            mode_quality_d = 32'd0;
            valid_found_d  = 1'b0;
            best_mode_d    = 2'd0;
            best_quality_d = 8'd0;
            best_bin_d     = 3'd0;
            if (mode_mask != 4'd0) begin
              nb        = next_bit(mode_mask, 3'd0);
              idx_d     = nb[1:0];
              rx_mode_d = nb[1:0];
              state_d   = ST_CLEAR;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_CLEAR: begin
          if (SETTLE_CYCLES == 0) begin
            cnt_d   = WINDOW_LOAD;
            state_d = ST_MEASURE;
          end else begin
            cnt_d   = SETTLE_LOAD;
            state_d = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == 32'd0) begin
            cnt_d   = WINDOW_LOAD;
            state_d = ST_MEASURE;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        ST_MEASURE: begin
          if (cnt_q == 32'd0) state_d = ST_CAPTURE;
          else                cnt_d   = cnt_q - 32'd1;
        end
        ST_CAPTURE: begin
          mode_ok = (scorer_edge_count >= MIN_EDGES_16) &&
                    ({24'd0, scorer_quality} >= MIN_QUALITY);
          mode_quality_d[{idx_q, 3'b000} +: 8] = mode_ok ? scorer_quality : 8'd0;
          // Strict greater-than keeps the lower index on ties.
          if (mode_ok && (!valid_found_q || (scorer_quality > best_quality_q))) begin
            valid_found_d  = 1'b1;
            best_mode_d    = idx_q;
            best_quality_d = scorer_quality;
            best_bin_d     = scorer_best_bin;
          end
          state_d = ST_NEXT;
        end
        ST_NEXT: begin
          nb = next_bit(mask_q, {1'b0, idx_q} + 3'd1);
          if (nb[2]) begin
            idx_d     = nb[1:0];
            rx_mode_d = nb[1:0];
            state_d   = ST_CLEAR;
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 32'd0;
      idx_q          <= 2'd0;
      mask_q         <= 4'd0;
      rx_mode_q      <= 2'd0;
      aborted_q      <= 1'b0;
      valid_found_q  <= 1'b0;
      best_mode_q    <= 2'd0;
      best_quality_q <= 8'd0;
      best_bin_q     <= 3'd0;
      mode_quality_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      mask_q         <= mask_d;
      rx_mode_q      <= rx_mode_d;
      aborted_q      <= aborted_d;
      valid_found_q  <= valid_found_d;
      best_mode_q    <= best_mode_d;
      best_quality_q <= best_quality_d;
      best_bin_q     <= best_bin_d;
      mode_quality_q <= mode_quality_d;
    end
  end

  assign rx_mode       = rx_mode_q;
  assign scorer_clear  = (state_q == ST_CLEAR);
  assign scorer_enable = (state_q == ST_MEASURE);
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign aborted       = aborted_q;
  assign valid_found   = valid_found_q;
  assign best_mode     = best_mode_q;
  assign best_quality  = best_quality_q;
  assign best_bin      = best_bin_q;
  assign mode_quality  = mode_quality_q;

endmodule

// File: tb/tb_interface_probe_sequencer.sv
// Directed bench for interface_probe_sequencer: table of full sweeps plus
// hand-written abort, reset and zero-settle sequences.
module tb_interface_probe_sequencer;

  localparam int SETTLE = 4;
  localparam int WINDOW = 64;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, abort, start_z;
  logic [3:0]  mode_mask;
  logic [1:0]  rx_mode, rx_mode_z;
  logic        scorer_clear, scorer_enable, busy, done, aborted, valid_found;
  logic [1:0]  best_mode;
  logic [7:0]  best_quality;
  logic [2:0]  best_bin;
  logic [31:0] mode_quality;
  logic        scorer_clear_z, scorer_enable_z, busy_z, done_z, aborted_z, valid_found_z;
  logic [1:0]  best_mode_z;
  logic [7:0]  best_quality_z;
  logic [2:0]  best_bin_z;
  logic [31:0] mode_quality_z;

  // Scorer model: per-mode result tables indexed by the selected receiver mode
  logic [7:0]  tq[4];
  logic [15:0] te[4];
  logic [2:0]  tbin[4];
  logic [7:0]  scorer_quality, scorer_quality_z;
  logic [15:0] scorer_edge_count, scorer_edge_count_z;
  logic [2:0]  scorer_best_bin, scorer_best_bin_z;
  assign scorer_quality      = tq[rx_mode];
  assign scorer_edge_count   = te[rx_mode];
  assign scorer_best_bin     = tbin[rx_mode];
  assign scorer_quality_z    = tq[rx_mode_z];
  assign scorer_edge_count_z = te[rx_mode_z];
  assign scorer_best_bin_z   = tbin[rx_mode_z];

  interface_probe_sequencer #(
    .SETTLE_CYCLES(SETTLE), .WINDOW_CYCLES(WINDOW), .MIN_EDGES(8), .MIN_QUALITY(96)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode_mask(mode_mask),
    .rx_mode(rx_mode), .scorer_clear(scorer_clear), .scorer_enable(scorer_enable),
    .scorer_quality(scorer_quality), .scorer_edge_count(scorer_edge_count),
    .scorer_best_bin(scorer_best_bin), .busy(busy), .done(done), .aborted(aborted),
    .valid_found(valid_found), .best_mode(best_mode), .best_quality(best_quality),
    .best_bin(best_bin), .mode_quality(mode_quality)
  );

  interface_probe_sequencer #(
    .SETTLE_CYCLES(0), .WINDOW_CYCLES(WINDOW), .MIN_EDGES(8), .MIN_QUALITY(96)
  ) dut_z (
    .clk(clk), .reset(reset), .start(start_z), .abort(1'b0), .mode_mask(mode_mask),
    .rx_mode(rx_mode_z), .scorer_clear(scorer_clear_z), .scorer_enable(scorer_enable_z),
    .scorer_quality(scorer_quality_z), .scorer_edge_count(scorer_edge_count_z),
    .scorer_best_bin(scorer_best_bin_z), .busy(busy_z), .done(done_z), .aborted(aborted_z),
    .valid_found(valid_found_z), .best_mode(best_mode_z), .best_quality(best_quality_z),
    .best_bin(best_bin_z), .mode_quality(mode_quality_z)
  );

  // Event monitor: cumulative counters, sampled on the falling edge
  int clr_cnt = 0, busy_cnt = 0, done_cnt = 0, abort_cnt = 0;
  int en_cnt[4] = '{0, 0, 0, 0};
  int clr_z = 0, en_z = 0, adj_z = 0, done_z_cnt = 0;
  logic prev_clr_z = 1'b0;
  always @(negedge clk) begin
    if (scorer_clear)  clr_cnt++;
    if (scorer_enable) en_cnt[rx_mode]++;
    if (busy)          busy_cnt++;
    if (done)          done_cnt++;
    if (aborted)       abort_cnt++;
    if (scorer_clear_z)  clr_z++;
    if (scorer_enable_z) en_z++;
    if (prev_clr_z && scorer_enable_z) adj_z++;
    if (done_z)          done_z_cnt++;
    prev_clr_z = scorer_clear_z;
  end

  // Scoreboard counters
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] q;      // byte m = quality for mode m
    logic [63:0] e;      // 16-bit field m = edge count for mode m
    logic [11:0] b;      // 3-bit field m = best bin for mode m
    int          poke_cyc;
    logic [3:0]  poke_mask;
    logic        exp_valid;
    logic [1:0]  exp_mode;
    logic [7:0]  exp_q;
    logic [2:0]  exp_bin;
    logic [31:0] exp_mq;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic load_scorer(input int i);
    for (int m = 0; m < 4; m++) begin
      tq[m]   = vecs[i].q[m*8 +: 8];
      te[m]   = vecs[i].e[m*16 +: 16];
      tbin[m] = vecs[i].b[m*3 +: 3];
    end
  endtask

  // Driver: pulse start with mask, optionally re-pulse start at poke_cyc, report
  // the cycle offset at which done is seen (-1 if the budget runs out).
  task automatic run_sweep(input logic [3:0] mask, input int poke_cyc,
                           input logic [3:0] poke_mask, output int lat);
    @(negedge clk);
    mode_mask = mask;
    start     = 1'b1;
    lat       = -1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == poke_cyc) begin
        start     = 1'b1;
        mode_mask = poke_mask;
      end
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic apply_vec(input int i);
    int lat;
    int b_clr, b_busy, b_done, b_abt;
    int b_en[4];
    load_scorer(i);
    b_clr = clr_cnt; b_busy = busy_cnt; b_done = done_cnt; b_abt = abort_cnt;
    for (int m = 0; m < 4; m++) b_en[m] = en_cnt[m];
    run_sweep(vecs[i].mask, vecs[i].poke_cyc, vecs[i].poke_mask, lat);
    @(negedge clk);
    check($sformatf("v%0d_done_latency", i), lat, vecs[i].exp_lat);
    check($sformatf("v%0d_valid_found", i), valid_found, vecs[i].exp_valid);
    check($sformatf("v%0d_best_mode", i), best_mode, vecs[i].exp_mode);
    check($sformatf("v%0d_best_quality", i), best_quality, vecs[i].exp_q);
    check($sformatf("v%0d_best_bin", i), best_bin, vecs[i].exp_bin);
    check($sformatf("v%0d_mode_quality", i), mode_quality, vecs[i].exp_mq);
    check($sformatf("v%0d_clear_cycles", i), clr_cnt - b_clr, $countones(vecs[i].mask));
    check($sformatf("v%0d_busy_cycles", i), busy_cnt - b_busy, vecs[i].exp_lat);
    check($sformatf("v%0d_done_pulses", i), done_cnt - b_done, 1);
    check($sformatf("v%0d_abort_pulses", i), abort_cnt - b_abt, 0);
    check($sformatf("v%0d_idle_after", i), busy, 1'b0);
    for (int m = 0; m < 4; m++)
      check($sformatf("v%0d_enable_cycles_m%0d", i, m), en_cnt[m] - b_en[m],
            vecs[i].mask[m] ? WINDOW : 0);
  endtask

  initial begin
    int n, b_done, lat;
    reset = 1'b1; start = 1'b0; abort = 1'b0; start_z = 1'b0; mode_mask = 4'd0;
    for (int m = 0; m < 4; m++) begin tq[m] = 8'd0; te[m] = 16'd0; tbin[m] = 3'd0; end

    //               mask  q (m3..m0)                              e (m3..m0)                                    b (m3..m0)                      poke     valid mode  q       bin    mode_quality   lat
    vecs[0] = '{4'hF, {8'd200, 8'd150, 8'd200, 8'd100}, {16'd500, 16'd500, 16'd500, 16'd500}, {3'd4, 3'd3, 3'd2, 3'd1}, 0, 4'h0,  1'b1, 2'd1, 8'd200, 3'd2, 32'hC896_C864, 285};
    vecs[1] = '{4'h5, {8'd0, 8'd97, 8'd0, 8'd255},      {16'd0, 16'd500, 16'd0, 16'd4},       {3'd0, 3'd6, 3'd0, 3'd5}, 30, 4'hA, 1'b1, 2'd2, 8'd97,  3'd6, 32'h0061_0000, 143};
    vecs[2] = '{4'h0, {8'd9, 8'd9, 8'd9, 8'd9},         {16'd900, 16'd900, 16'd900, 16'd900}, {3'd1, 3'd1, 3'd1, 3'd1}, 0, 4'h0,  1'b0, 2'd0, 8'd0,   3'd0, 32'h0000_0000, 1};
    vecs[3] = '{4'hA, {8'd95, 8'd0, 8'd96, 8'd0},       {16'd500, 16'd0, 16'd8, 16'd0},       {3'd3, 3'd0, 3'd7, 3'd0}, 0, 4'h0,  1'b1, 2'd1, 8'd96,  3'd7, 32'h0000_6000, 143};
    vecs[4] = '{4'h8, {8'd255, 8'd0, 8'd0, 8'd0},       {16'd7, 16'd0, 16'd0, 16'd0},         {3'd6, 3'd0, 3'd0, 3'd0}, 0, 4'h0,  1'b0, 2'd0, 8'd0,   3'd0, 32'h0000_0000, 72};
    vecs[5] = '{4'hC, {8'd151, 8'd150, 8'd0, 8'd0},     {16'd500, 16'd500, 16'd500, 16'd500}, {3'd5, 3'd2, 3'd0, 3'd0}, 0, 4'h0,  1'b1, 2'd3, 8'd151, 3'd5, 32'h9796_0000, 143};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_strobes", {scorer_clear, scorer_enable, done, aborted}, 4'd0);
    check("reset_results", {valid_found, best_mode, best_quality, best_bin, rx_mode}, 16'd0);
    check("reset_mode_quality", mode_quality, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) apply_vec(i);

    // Abort during mode 2 measurement
    load_scorer(0);
    b_done = done_cnt;
    @(negedge clk);
    mode_mask = 4'hF;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(rx_mode == 2'd2 && scorer_enable) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_mode2_measure", n < 400, 1'b1);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_pulse", aborted, 1'b1);
    check("abort_idle", busy, 1'b0);
    check("abort_enable_low", scorer_enable, 1'b0);
    check("abort_mode_quality", mode_quality, 32'h0000_C864);
    check("abort_best", {valid_found, best_mode, best_quality, best_bin}, {1'b1, 2'd1, 8'd200, 3'd2});
    @(negedge clk);
    check("abort_pulse_one_cycle", aborted, 1'b0);
    repeat (5) @(negedge clk);
    check("abort_no_done", done_cnt - b_done, 0);
    apply_vec(0);

    // Reset during mode 1 settle
    load_scorer(0);
    @(negedge clk);
    mode_mask = 4'hF;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (73) @(negedge clk);
    check("pre_reset_settle", {busy, rx_mode, scorer_clear, scorer_enable}, {1'b1, 2'd1, 1'b0, 1'b0});
    check("pre_reset_mode0_captured", mode_quality, 32'h0000_0064);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_busy", busy, 1'b0);
    check("midreset_strobes", {scorer_clear, scorer_enable, done, aborted}, 4'd0);
    check("midreset_results", {valid_found, best_mode, best_quality, best_bin, rx_mode}, 16'd0);
    check("midreset_mode_quality", mode_quality, 32'd0);
    apply_vec(0);

    // Zero-settle instance: clear is followed directly by enable
    load_scorer(0);
    b_done = done_z_cnt;
    n = clr_z; lat = en_z;
    begin
      int a0, l;
      a0 = adj_z;
      l  = -1;
      @(negedge clk);
      mode_mask = 4'b0110;
      start_z   = 1'b1;
      for (int k = 1; k <= 400; k++) begin
        @(negedge clk);
        start_z = 1'b0;
        if (done_z) begin
          l = k;
          break;
        end
      end
      start_z = 1'b0;
      @(negedge clk);
      check("z_done_latency", l, 1 + 2 * (WINDOW + 3));
      check("z_clear_cycles", clr_z - n, 2);
      check("z_enable_cycles", en_z - lat, 2 * WINDOW);
      check("z_clear_then_enable", adj_z - a0, 2);
      check("z_done_pulses", done_z_cnt - b_done, 1);
      check("z_mode_quality", mode_quality_z, 32'h0096_C800);
      check("z_best", {valid_found_z, best_mode_z, best_quality_z}, {1'b1, 2'd1, 8'd200});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
